// File: rtl/pending_event_encoder.sv
// Pending-event encoder: request pulses are held in a sticky pending register
// and presented one index at a time on a Valid/Ready handshake.
module pending_event_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic [WIDTH-1:0] In,
    input  logic             Mode,
    input  logic             Ready,
    input  logic             ClearOvf,
    output logic [IDX_W-1:0] Out,
    output logic             Valid,
    output logic             Good,
    output logic [WIDTH-1:0] Pending,
    output logic             Overflow
);

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // One-hot decode of an index, limited to the WIDTH existing lines.
    function automatic logic [WIDTH-1:0] onehot(input logic [IDX_W-1:0] idx);
        logic [WIDTH-1:0] vec;
        vec = '0;
        for (int i = 0; i < WIDTH; i++) begin
            vec[i] = (IDX_W'(i) == idx);
        end
        return vec;
    endfunction

    // First set index at or above start, wrapping modulo WIDTH. The vector is
    // rotated so the search is always a lowest-set-bit scan.
    function automatic logic [IDX_W-1:0] sel_index(input logic [WIDTH-1:0] vec,
                                                   input logic [IDX_W-1:0] start);
        logic [WIDTH-1:0] rot;
        logic             found;
        int               pos;
        logic [IDX_W-1:0] result;
        rot    = WIDTH'({vec, vec} >> start);
        found  = 1'b0;
        pos    = 0;
        result = '0;
        for (int k = 0; k < WIDTH; k++) begin
            if (!found && rot[k]) begin
                found = 1'b1;
                pos   = int'(start) + k;
                if (pos >= WIDTH) begin
                    pos = pos - WIDTH;
                end else begin
                    pos = pos;
                end
                result = IDX_W'(pos);
            end else begin
                found = found;
            end
        end
        return result;
    endfunction

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] pend_r;
    logic [IDX_W-1:0] out_r;
    logic             valid_r;
    logic             good_r;
    logic             ovf_r;
    logic [IDX_W-1:0] ptr_r;

    logic             transfer_s;
    logic [WIDTH-1:0] clr_s;
    logic [WIDTH-1:0] keep_s;
    logic [WIDTH-1:0] pend_next_s;
    logic             ovf_set_s;
    logic             ovf_next_s;
    logic [IDX_W-1:0] ptr_next_s;
    logic [IDX_W-1:0] out_next_s;
    logic             valid_next_s;
    logic [IDX_W-1:0] start_idle_s;
    logic [IDX_W-1:0] start_hold_s;

    // Pending-register datapath, overflow detection and round-robin pointer.
    always_comb begin
        transfer_s  = valid_r & Ready;
        clr_s       = '0;
        ptr_next_s  = ptr_r;
        if (transfer_s) begin
            clr_s = onehot(out_r);
            if (out_r == IDX_W'(WIDTH - 1)) begin
                ptr_next_s = '0;
            end else begin
                ptr_next_s = out_r + IDX_W'(1);
            end
        end else begin
            clr_s      = '0;
            ptr_next_s = ptr_r;
        end
        // keep_s excludes same-cycle requests, so a re-request of the line
        // being transferred is a fresh event rather than an overflow.
        keep_s      = pend_r & ~clr_s;
        pend_next_s = keep_s | In;
        ovf_set_s   = |(In & keep_s);
        if (ovf_set_s) begin
            ovf_next_s = 1'b1;
        end else if (ClearOvf) begin
            ovf_next_s = 1'b0;
        end else begin
            ovf_next_s = ovf_r;
        end
        start_idle_s = Mode ? ptr_r : '0;
        start_hold_s = Mode ? ptr_next_s : '0;
    end

    // Next-state and presented-index selection for the handshake FSM.
    always_comb begin
        state_next_s = state_r;
        out_next_s   = out_r;
        valid_next_s = valid_r;
        case (state_r)
            IDLE: begin
                if (|pend_r) begin
                    out_next_s   = sel_index(pend_r, start_idle_s);
                    valid_next_s = 1'b1;
                    state_next_s = HOLD;
                end else begin
                    valid_next_s = 1'b0;
                    state_next_s = IDLE;
                end
            end
            HOLD: begin
                if (!transfer_s) begin
                    valid_next_s = 1'b1;
                    state_next_s = HOLD;
                end else if (|keep_s) begin
                    out_next_s   = sel_index(keep_s, start_hold_s);
                    valid_next_s = 1'b1;
                    state_next_s = HOLD;
                end else begin
                    valid_next_s = 1'b0;
                    state_next_s = IDLE;
                end
            end
            default: begin
                valid_next_s = 1'b0;
                state_next_s = IDLE;
            end
        endcase
    end

    // State and output registers; Reset overrides any handshake in flight.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= IDLE;
            pend_r  <= '0;
            out_r   <= '0;
            valid_r <= 1'b0;
            good_r  <= 1'b0;
            ovf_r   <= 1'b0;
            ptr_r   <= '0;
        end else begin
            state_r <= state_next_s;
            pend_r  <= pend_next_s;
            out_r   <= out_next_s;
            valid_r <= valid_next_s;
            good_r  <= |pend_next_s;
            ovf_r   <= ovf_next_s;
            ptr_r   <= ptr_next_s;
        end
    end

    assign Out      = out_r;
    assign Valid    = valid_r;
    assign Good     = good_r;
    assign Pending  = pend_r;
    assign Overflow = ovf_r;

endmodule

// File: tb/tb_pending_event_encoder.sv
// Self-checking bench for pending_event_encoder: directed tables and sequences
// plus randomized traffic against an index-level reference model.
module tb_pending_event_encoder;

    logic       clk;
    logic       reset;
    logic [7:0] inVec;
    logic       mode;
    logic       ready;
    logic       clrOvf;
    logic [2:0] out8;
    logic       valid8;
    logic       good8;
    logic [7:0] pend8;
    logic       ovf8;

    logic       reset5;
    logic [4:0] in5;
    logic       mode5;
    logic       ready5;
    logic       clr5;
    logic [2:0] out5;
    logic       valid5;
    logic       good5;
    logic [4:0] pend5;
    logic       ovf5;

    int errors = 0;
    int checks = 0;

    pending_event_encoder #(.WIDTH(8), .IDX_W(3)) dut8 (
        .Clk(clk), .Reset(reset), .In(inVec), .Mode(mode), .Ready(ready),
        .ClearOvf(clrOvf), .Out(out8), .Valid(valid8), .Good(good8),
        .Pending(pend8), .Overflow(ovf8)
    );

    pending_event_encoder #(.WIDTH(5), .IDX_W(3)) dut5 (
        .Clk(clk), .Reset(reset5), .In(in5), .Mode(mode5), .Ready(ready5),
        .ClearOvf(clr5), .Out(out5), .Valid(valid5), .Good(good5),
        .Pending(pend5), .Overflow(ovf5)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a set of pending lines, the presented index and a pointer.
    bit mPend[8];
    int mOut;
    bit mValid;
    bit mOvf;
    int mPtr;

    function automatic int pick(input bit v[8], input int start);
        for (int k = 0; k < 8; k++) begin
            if (v[(start + k) % 8]) return (start + k) % 8;
        end
        return -1;
    endfunction

    function automatic logic [7:0] packPend();
        logic [7:0] p;
        for (int i = 0; i < 8; i++) p[i] = mPend[i];
        return p;
    endfunction

    task automatic modelStep();
        bit old[8];
        bit xfer;
        bit ovfHit;
        bit cleared;
        int g;
        int n;
        if (reset) begin
            for (int i = 0; i < 8; i++) mPend[i] = 1'b0;
            mOut = 0; mValid = 1'b0; mOvf = 1'b0; mPtr = 0;
        end else begin
            xfer = mValid && ready;
            g = mOut;
            ovfHit = 1'b0;
            for (int i = 0; i < 8; i++) old[i] = mPend[i];
            for (int i = 0; i < 8; i++) begin
                cleared = xfer && (i == g);
                if (inVec[i] && old[i] && !cleared) ovfHit = 1'b1;
                mPend[i] = (old[i] && !cleared) || inVec[i];
            end
            if (ovfHit) mOvf = 1'b1;
            else if (clrOvf) mOvf = 1'b0;
            if (xfer) mPtr = (g + 1) % 8;
            if (!mValid) begin
                n = pick(old, mode ? mPtr : 0);
                if (n >= 0) begin
                    mOut = n; mValid = 1'b1;
                end
            end else if (xfer) begin
                old[g] = 1'b0;
                n = pick(old, mode ? mPtr : 0);
                if (n >= 0) mOut = n;
                else mValid = 1'b0;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkModel();
        bit anyP;
        anyP = 1'b0;
        for (int i = 0; i < 8; i++) anyP = anyP | mPend[i];
        chk("model_out", out8, 32'(mOut));
        chk("model_valid", valid8, mValid);
        chk("model_good", good8, anyP);
        chk("model_pending", pend8, packPend());
        chk("model_overflow", ovf8, mOvf);
    endtask

    task automatic tick();
        @(posedge clk);
        modelStep();
        @(negedge clk);
        checkModel();
    endtask

    task automatic doReset();
        reset = 1'b1; inVec = 8'h00; clrOvf = 1'b0; ready = 1'b0; mode = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [7:0]  inVec;
        logic        mode;
        int          n;
        logic [31:0] seq;
    } vec_t;

    vec_t       tbl[7];
    logic [7:0] one;

    initial begin
        tbl[0] = '{inVec: 8'h01, mode: 1'b0, n: 1, seq: 32'h0000_0000};
        tbl[1] = '{inVec: 8'hA4, mode: 1'b0, n: 3, seq: 32'h0000_0752};
        tbl[2] = '{inVec: 8'h81, mode: 1'b1, n: 2, seq: 32'h0000_0070};
        tbl[3] = '{inVec: 8'hFF, mode: 1'b0, n: 8, seq: 32'h7654_3210};
        tbl[4] = '{inVec: 8'h96, mode: 1'b1, n: 4, seq: 32'h0000_7421};
        tbl[5] = '{inVec: 8'h30, mode: 1'b0, n: 2, seq: 32'h0000_0054};
        tbl[6] = '{inVec: 8'h80, mode: 1'b1, n: 1, seq: 32'h0000_0007};

        reset = 1'b1; inVec = 8'h00; mode = 1'b0; ready = 1'b0; clrOvf = 1'b0;
        reset5 = 1'b1; in5 = 5'h00; mode5 = 1'b0; ready5 = 1'b0; clr5 = 1'b0;
        doReset();
        chk("reset_valid", valid8, 1'b0);
        chk("reset_out", out8, 3'd0);
        chk("reset_pending", pend8, 8'h00);

        // Table of single bursts, each drained back-to-back from reset.
        for (int e = 0; e < 7; e++) begin
            doReset();
            mode = tbl[e].mode; ready = 1'b1; inVec = tbl[e].inVec;
            tick();
            inVec = 8'h00;
            chk("burst_latency", valid8, 1'b0);
            for (int j = 0; j < tbl[e].n; j++) begin
                tick();
                chk("burst_valid", valid8, 1'b1);
                chk("burst_out", out8, 32'(tbl[e].seq[4*j +: 4]));
            end
            tick();
            chk("burst_done_valid", valid8, 1'b0);
            chk("burst_done_good", good8, 1'b0);
        end

        // Walking one, fixed priority, one pulse every 10 cycles.
        doReset();
        ready = 1'b1; one = 8'h01;
        for (int s = 0; s < 9; s++) begin
            inVec = one << s;
            tick();
            inVec = 8'h00;
            chk("walk_latency", valid8, 1'b0);
            for (int t = 1; t < 10; t++) begin
                tick();
                if (s < 8 && t == 1) begin
                    chk("walk_valid", valid8, 1'b1);
                    chk("walk_out", out8, 32'(s));
                end else begin
                    chk("walk_idle", valid8, 1'b0);
                end
                chk("walk_ovf", ovf8, 1'b0);
            end
        end

        // Fixed priority held under Ready=0, then drained.
        doReset();
        inVec = 8'hA4;
        tick();
        inVec = 8'h00;
        for (int t = 0; t < 4; t++) begin
            tick();
            chk("fp_hold_valid", valid8, 1'b1);
            chk("fp_hold_out", out8, 3'd2);
        end
        ready = 1'b1;
        tick(); chk("fp_out5", out8, 3'd5);
        tick(); chk("fp_out7", out8, 3'd7);
        tick(); chk("fp_end_valid", valid8, 1'b0); chk("fp_end_good", good8, 1'b0);

        // Round-robin fairness with a continuously held request.
        doReset();
        mode = 1'b1; ready = 1'b1; inVec = 8'h81;
        tick(); chk("rr_ovf0", ovf8, 1'b0);
        tick(); chk("rr_out0a", out8, 3'd0); chk("rr_ovf1", ovf8, 1'b1);
        tick(); chk("rr_out7a", out8, 3'd7);
        tick(); chk("rr_out0b", out8, 3'd0);
        tick(); chk("rr_out7b", out8, 3'd7);
        clrOvf = 1'b1;
        tick(); chk("rr_clr_held", ovf8, 1'b1);
        inVec = 8'h00;
        tick(); chk("rr_clr_done", ovf8, 1'b0);
        clrOvf = 1'b0;
        for (int t = 0; t < 3; t++) tick();
        chk("rr_drained", valid8, 1'b0);

        // Backpressure: index 6 stays presented while a higher-priority event arrives.
        doReset();
        one = 8'h40; inVec = one;
        tick();
        inVec = 8'h00;
        tick(); chk("bp_first", out8, 3'd6);
        for (int t = 0; t < 5; t++) begin
            inVec = (t == 1) ? 8'h02 : 8'h00;
            tick();
            chk("bp_hold_out", out8, 3'd6);
            chk("bp_hold_valid", valid8, 1'b1);
        end
        inVec = 8'h00; ready = 1'b1;
        tick(); chk("bp_next", out8, 3'd1); chk("bp_next_valid", valid8, 1'b1);
        tick(); chk("bp_end", valid8, 1'b0);

        // Reset in the middle of a transfer drops everything.
        doReset();
        inVec = 8'hFF;
        tick();
        tick();
        inVec = 8'h00;
        chk("rst_pre_valid", valid8, 1'b1);
        chk("rst_pre_ovf", ovf8, 1'b1);
        ready = 1'b1; reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rst_valid", valid8, 1'b0);
        chk("rst_out", out8, 3'd0);
        chk("rst_good", good8, 1'b0);
        chk("rst_pending", pend8, 8'h00);
        chk("rst_ovf", ovf8, 1'b0);
        tick(); chk("rst_no_event", valid8, 1'b0);

        // Five-line instance, round-robin.
        reset5 = 1'b1;
        tick();
        reset5 = 1'b0; mode5 = 1'b1; ready5 = 1'b1; in5 = 5'h1F;
        tick();
        in5 = 5'h00;
        chk("w5_latency", valid5, 1'b0);
        for (int j = 0; j < 5; j++) begin
            tick();
            chk("w5_valid", valid5, 1'b1);
            chk("w5_out", out5, 32'(j));
        end
        tick(); chk("w5_end", valid5, 1'b0); chk("w5_good", good5, 1'b0);
        for (int t = 0; t < 40; t++) begin
            in5 = 5'($urandom);
            mode5 = 1'($urandom);
            ready5 = 1'($urandom);
            tick();
            chk("w5_range", (out5 < 3'd5), 1'b1);
        end

        // Randomized traffic against the model.
        doReset();
        for (int c = 0; c < 3000; c++) begin
            inVec  = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00;
            if ($urandom_range(0, 15) == 0) mode = ~mode;
            ready  = ($urandom_range(0, 2) != 0);
            clrOvf = ($urandom_range(0, 7) == 0);
            reset  = ($urandom_range(0, 199) == 0);
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/pending_event_encoder.md
Name: pending_event_encoder

Overview:
- Parametrised, clocked successor to the combinational 8-to-3 encoder.
- Captures request pulses on WIDTH input lines into a sticky pending register.
- Emits one encoded index per accepted transfer on a Valid/Ready handshake.
- Selection is fixed-priority or round-robin.
- Sits between raw event sources (switches, pulse detectors) and a consumer that processes one event index at a time.

Parameters:
- WIDTH, 8, number of request lines (2..256).
- IDX_W, 3, width of encoded index; WIDTH <= 2**IDX_W required.

Ports:
- Clk  in  1  rising-edge clock.
- Reset  in  1  synchronous, active-high reset.
- In  in  WIDTH  request lines; any bit high at an edge records an event on that line.
- Mode  in  1  0 = fixed priority (index 0 highest), 1 = round-robin.
- Ready  in  1  consumer accepts Out this cycle.
- Out  out  IDX_W  encoded index of the presented event.
- Valid  out  1  Out holds a pending event.
- Good  out  1  registered; 1 when any pending bit is set.
- Pending  out  WIDTH  pending register P, for debug.
- Overflow  out  1  sticky; an event arrived on a line already pending.
- ClearOvf  in  1  clears Overflow.

Behaviour:
- Reset values (Reset high at an edge): P=0, Out=0, Valid=0, Good=0, Overflow=0, round-robin pointer Ptr=0, FSM=IDLE.
- Reset has priority over every other input. Reset mid-transfer drops all pending events; no handshake completes that cycle.
- Handshake: a transfer occurs at an edge where Valid=1 and Ready=1. Call the transferred index g = Out.
- P update each edge: P <= (P & ~clr) | In.
  - clr = onehot(g) when a transfer occurs, else 0.
  - If In[g] is high in the transfer cycle, bit g stays set as a new event. This does not count as overflow.
- Overflow sets at an edge where In[i]=1, P[i]=1 and bit i is not being cleared by a transfer that cycle.
  - Overflow clears on ClearOvf=1.
  - Set wins if both happen in the same cycle.
- Good <= |P_next, so it is registered and tracks P.
- Selection function sel(V), given vector V:
  - Mode=0: lowest set index of V.
  - Mode=1: first set index at or above Ptr, wrapping modulo WIDTH.
  - Mode is sampled at the edge that loads Out.
- FSM:
  - IDLE: Valid=0. At an edge with P != 0, load Out <= sel(P), Valid <= 1, go to HOLD.
  - HOLD: Valid=1. Out stays stable while Ready=0, even if higher-priority events arrive.
  - HOLD, on transfer: Ptr <= (g+1) mod WIDTH.
    - Let R = P & ~onehot(g), using registered P; same-cycle In is excluded.
    - If R != 0: Out <= sel(R) with the updated Ptr, stay in HOLD. This gives one transfer per cycle back-to-back.
    - If R = 0: Valid <= 0, go to IDLE.
- Latency: In sampled at edge E0 sets P after E0. With the FSM in IDLE, Valid=1 after edge E1, i.e. 2 edges from In to Valid.
- Ptr updates on every transfer in both modes but is used only when Mode=1.
- Out is never an index >= WIDTH. Bits of In above WIDTH-1 do not exist.
- Out keeps its last value while Valid=0.

Test Plan:
- Walking one: WIDTH=8, Ready=1, In=8'b0000_0001 shifted left each 10 cycles, pulsed for 1 cycle, 9 steps.
  - Required: Out = 0..7 in turn, each with Valid high for exactly 1 cycle, 2 edges after the pulse.
  - Final shift to 0 produces no Valid. Overflow stays 0.
- Fixed priority: Mode=0, Ready=0, pulse In=8'hA4.
  - Required: Valid=1, Out=2, held stable.
  - Then Ready=1: Out sequence 2, 5, 7 on consecutive cycles, then Valid=0 and Good=0.
- Round-robin fairness: Mode=1, Ready=1, In=8'h81 held high continuously.
  - Required: Out alternates 0, 7, 0, 7 and Overflow=1 after the second cycle.
  - ClearOvf=1 with In still high: Overflow remains 1.
  - ClearOvf=1 with In=0: Overflow=0.
- Backpressure stability: Mode=0, pulse In[6], Ready=0 for 5 cycles, pulse In[1] during the hold.
  - Required: Out=6 throughout the hold.
  - After Ready=1: Out=6, then Out=1.
- Reset mid-operation: P=8'hFF with Valid=1, assert Reset 1 cycle with Ready=1.
  - Required next cycle: Valid=0, Out=0, Good=0, Pending=0, Overflow=0; no event delivered.
- Parameter sweep: WIDTH=5, IDX_W=3, Mode=1, In=5'b11111 pulsed.
  - Required: Out = 0, 1, 2, 3, 4, then Valid=0; Out never takes values 5..7.
